// File: rtl/dispatch_queue_pkg.sv
// Shared widths and packet type for the decode-to-RS dispatch queue.
package dispatch_queue_pkg;

  localparam int DEFAULT_DEPTH = 4;
  localparam int OPCODE_WIDTH  = 5;
  localparam int ADDR_WIDTH    = 32;
  localparam int DATA_WIDTH    = 32;
  localparam int TAG_WIDTH     = 6;

  typedef logic [OPCODE_WIDTH-1:0] opcode_t;
  typedef logic [ADDR_WIDTH-1:0]   addr_t;
  typedef logic [DATA_WIDTH-1:0]   data_t;
  typedef logic [TAG_WIDTH-1:0]    tag_t;

  // One dispatch packet; the field order is also the storage bit order.
  typedef struct packed {
    opcode_t opcode;
    addr_t   pc;
    data_t   insn;
    tag_t    dst_tag;
  } dispatch_packet_t;

endpackage

// File: rtl/dispatch_queue_if.sv
// Decode-side and RS-side signals of the dispatch queue.
// Handshake: a packet moves in on a clock edge when i_en=1, i_rob_stall=0,
// o_full=0 and i_flush=0; the head moves out on an edge when o_rs_en=1,
// i_rs_stall=0 and i_flush=0. o_full/o_rs_en depend on registered state only.
interface dispatch_queue_if
  import dispatch_queue_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int OPC_W  = OPCODE_WIDTH,
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int DATA_W = DATA_WIDTH,
  parameter int TAG_W  = TAG_WIDTH
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              i_flush;
  logic              i_rob_stall;
  logic              i_rs_stall;
  logic              i_en;
  logic [OPC_W-1:0]  i_opcode;
  logic [ADDR_W-1:0] i_pc;
  logic [DATA_W-1:0] i_insn;
  logic [TAG_W-1:0]  i_dst_tag;
  logic              o_full;
  logic [CW-1:0]     o_count;
  logic              o_rs_en;
  logic [OPC_W-1:0]  o_rs_opcode;
  logic [ADDR_W-1:0] o_rs_pc;
  logic [DATA_W-1:0] o_rs_insn;
  logic [TAG_W-1:0]  o_rs_dst_tag;

  // Pipeline side (decode, ROB, RS control) drives the inputs.
  modport master (
    output i_flush, i_rob_stall, i_rs_stall, i_en,
    output i_opcode, i_pc, i_insn, i_dst_tag,
    input  o_full, o_count, o_rs_en,
    input  o_rs_opcode, o_rs_pc, o_rs_insn, o_rs_dst_tag
  );

  // The queue itself.
  modport slave (
    input  i_flush, i_rob_stall, i_rs_stall, i_en,
    input  i_opcode, i_pc, i_insn, i_dst_tag,
    output o_full, o_count, o_rs_en,
    output o_rs_opcode, o_rs_pc, o_rs_insn, o_rs_dst_tag
  );

endinterface

// File: rtl/dispatch_entry_ram.sv
// Packet storage: one write port, one asynchronous read port, cleared on reset.
module dispatch_entry_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 75
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage write; everything clears on reset so the head reads 0.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dispatch_queue.sv
// Buffered map/dispatch stage between decode and the reservation stations.
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int OPC_W  = OPCODE_WIDTH,
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int DATA_W = DATA_WIDTH,
  parameter int TAG_W  = TAG_WIDTH
) (
  input  logic          clk,
  input  logic          n_rst,
  dispatch_queue_if.slave dq
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PKT_W = OPC_W + ADDR_W + DATA_W + TAG_W;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;
  logic [PKT_W-1:0] wr_pkt;
  logic [PKT_W-1:0] rd_pkt;

  // Status comes from the registered count only.
  assign dq.o_full  = (count == FULL_CNT);
  assign dq.o_rs_en = (count != '0);
  assign dq.o_count = count;

  // Flush overrides both sides; a full queue refuses a push even when popping.
  assign push = dq.i_en & ~dq.i_rob_stall & ~dq.o_full & ~dq.i_flush;
  assign pop  = dq.o_rs_en & ~dq.i_rs_stall & ~dq.i_flush;

  assign wr_pkt = {dq.i_opcode, dq.i_pc, dq.i_insn, dq.i_dst_tag};

  dispatch_entry_ram #(
    .DEPTH (DEPTH),
    .WIDTH (PKT_W)
  ) u_ram (
    .clk     (clk),
    .n_rst   (n_rst),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_pkt),
    .rd_addr (rd_ptr),
    .rd_data (rd_pkt)
  );

  assign {dq.o_rs_opcode, dq.o_rs_pc, dq.o_rs_insn, dq.o_rs_dst_tag} = rd_pkt;

  // Pointer and occupancy bookkeeping; pointers wrap at DEPTH naturally.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (dq.i_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
